la_rle_capture: RTL
===================

LA_RLE_CAPTURE -- requirements
Module: la_rle_capture

Interface
REQ-001 Parameter pSIG_WIDTH, default 24: width of the probed signal bus.
REQ-002 Parameter pCNT_WIDTH, default 8: width of the run-length count field; pSIG_WIDTH+pCNT_WIDTH SHALL be a multiple of 8.
REQ-003 Parameter pFIFO_DEPTH, default 16: record FIFO depth, power of 2, at least 4.
REQ-004 Port axis_clk, in, 1: single clock for all logic.
REQ-005 Port axis_rst, in, 1: synchronous, active-high reset.
REQ-006 Port la_data, in, pSIG_WIDTH: probed signals, sampled every cycle.
REQ-007 Port la_mask, in, pSIG_WIDTH: monitor-enable per bit; a masked-off bit reads as 0.
REQ-008 Port la_enable, in, 1: capture enable; low acts as a soft clear.
REQ-009 Port trig_mode, in, 1: 0 = free-run; 1 = start on pattern match.
REQ-010 Ports trig_mask and trig_value, in, pSIG_WIDTH each: trigger pattern.
REQ-011 Ports hi_thresh and lo_thresh, in, clog2(pFIFO_DEPTH)+1 each: fill-level watermarks.
REQ-012 Ports m_tdata (pCNT_WIDTH+pSIG_WIDTH), m_tvalid, m_tlast, m_tuser[1:0], m_tstrb and m_tkeep ((pCNT+pSIG)/8), out: AXI-Stream master.
REQ-013 Port m_tready, in, 1: AXI-Stream ready.
REQ-014 Port la_hpri_req, out, 1: high-priority drain request.
REQ-015 Ports fifo_level (clog2(pFIFO_DEPTH)+1) and drop_cnt (16), out: status.

Function
REQ-016 Record format: m_tdata = {count[pCNT_WIDTH-1:0], signal[pSIG_WIDTH-1:0]}; count 0 = overflow marker.
REQ-017 Capture FSM: IDLE -> (la_enable & trig_mode=0) CAPTURE; IDLE -> (la_enable & trig_mode=1) ARMED; ARMED -> CAPTURE when (la_data & trig_mask) == (trig_value & trig_mask); any state -> IDLE when la_enable=0.
REQ-018 First CAPTURE cycle: cur = la_data & la_mask, cnt = 1; no record is emitted.
REQ-019 Later CAPTURE cycles: if the sample equals cur and cnt < 2^pCNT_WIDTH-1, then cnt+1; otherwise emit {cnt, cur} and set cur = sample, cnt = 1. A saturated count therefore forces an emit.
REQ-020 An emitted record is written to the FIFO in the same cycle, unless REQ-022 or REQ-023 applies.
REQ-021 A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-022 Emit while the FIFO is full with no pop: drop the record, set ovf_pend, increment drop_cnt (saturating at 0xFFFF).
REQ-023 When ovf_pend=1 and the push can be accepted: push marker {0, cur} with m_tuser[0]=1 and clear ovf_pend. If an emit also occurs that cycle, the emitted record is dropped and counted.
REQ-024 m_tuser[1]=1 on the first record after entering CAPTURE; otherwise 0.
REQ-025 m_tvalid = FIFO not empty; m_tdata and m_tuser show the FIFO head; a pop occurs on m_tvalid & m_tready.
REQ-026 Head data SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-027 m_tlast=1 when the head is the only FIFO entry; m_tstrb and m_tkeep are all ones.
REQ-028 la_hpri_req sets when fifo_level >= hi_thresh and clears when fifo_level <= lo_thresh; it holds otherwise (hysteresis). If hi_thresh <= lo_thresh, set takes priority.
REQ-029 la_enable=0 clears in the next cycle: FIFO emptied, cur/cnt/ovf_pend/drop_cnt zeroed, la_hpri_req=0. Any partial run is discarded.
REQ-030 Changing la_mask mid-capture takes effect on the next sample and can end the current run.

Reset
REQ-031 axis_rst=1 at a clock edge puts the FSM in IDLE and empties the FIFO.
REQ-032 Under reset, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, la_hpri_req=0, fifo_level=0 and drop_cnt=0.
REQ-033 Reset mid-transfer abandons the head record; no record survives reset.

Structure
REQ-034 Package la_pkg SHALL hold the state enum {IDLE, ARMED, CAPTURE}, the tuser bit indices (OVF=0, FIRST=1) and the marker count value 0.
REQ-035 The FIFO SHALL be a sub-module la_sync_fifo (parametrised width/depth, push/pop/full/empty/level), with show-ahead output.

Verification
REQ-036 Default parameters, mask=0xFFFFFF, free-run, tready=1; la_data 0x5A x3, then 0x55 -> record {0x03, 0x00005A} with tuser=2'b10.
REQ-037 mask=0x5A5A5A; la_data 0x5A then 0xFF -> both sample to 0x5A/0x5A5A5A... Use 0x00005A then 0x0000FF; both read as 0x00005A and merge into one run of count 2.
REQ-038 Constant la_data for 300 cycles -> records {0xFF, d} then {0x2D, d}, the second emitted on the next change.
REQ-039 tready=0, data changes every cycle -> 16 records accepted, later ones dropped, drop_cnt counts, la_hpri_req=1 at level >= hi_thresh. Release tready -> marker with count 0 and tuser[0]=1 after the 16 records; la_hpri_req clears at lo_thresh.
REQ-040 trig_mode=1, trig_mask=0xFF, trig_value=0x3C -> no records until la_data[7:0]=0x3C; the first record has tuser[1]=1.
REQ-041 la_enable dropped with 5 records queued -> next cycle m_tvalid=0 and fifo_level=0; re-enable restarts with cnt=1.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the run-length logic-analyser capture.
// Imported by the capture top and its record FIFO.
package la_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } la_state_e;

    localparam int TUSER_OVF   = 0;
    localparam int TUSER_FIRST = 1;
    localparam int MARKER_CNT  = 0;

endpackage

// File: rtl/la_sync_fifo.sv
// Single-clock show-ahead FIFO holding finished capture records.
// Head word is visible on rd_data whenever empty is low.
module la_sync_fifo
    import la_pkg::*;
#(
    parameter int pWIDTH = 34,
    parameter int pDEPTH = 16,
    localparam int AW = $clog2(pDEPTH)
) (
    input  logic              axis_clk,
    input  logic              axis_rst,
    input  logic              clr,
    input  logic              push,
    input  logic [pWIDTH-1:0] wr_data,
    input  logic              pop,
    output logic [pWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    logic [pWIDTH-1:0] mem [pDEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(pDEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; a clear drops every stored record at once.
    always_ff @(posedge axis_clk) begin
        if (axis_rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Record storage, written only on an accepted push.
    always_ff @(posedge axis_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/la_rle_capture.sv
// Logic-analyser front end: run-length encodes masked probe samples
// into {count, signal} records and streams them out over AXI-Stream.
module la_rle_capture
    import la_pkg::*;
#(
    parameter int pSIG_WIDTH  = 24,
    parameter int pCNT_WIDTH  = 8,
    parameter int pFIFO_DEPTH = 16,
    localparam int LW = $clog2(pFIFO_DEPTH) + 1,
    localparam int DW = pCNT_WIDTH + pSIG_WIDTH,
    localparam int KW = DW / 8
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst,
    input  logic [pSIG_WIDTH-1:0] la_data,
    input  logic [pSIG_WIDTH-1:0] la_mask,
    input  logic                  la_enable,
    input  logic                  trig_mode,
    input  logic [pSIG_WIDTH-1:0] trig_mask,
    input  logic [pSIG_WIDTH-1:0] trig_value,
    input  logic [LW-1:0]         hi_thresh,
    input  logic [LW-1:0]         lo_thresh,
    output logic [DW-1:0]         m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic [1:0]            m_tuser,
    output logic [KW-1:0]         m_tstrb,
    output logic [KW-1:0]         m_tkeep,
    input  logic                  m_tready,
    output logic                  la_hpri_req,
    output logic [LW-1:0]         fifo_level,
    output logic [15:0]           drop_cnt
);

    localparam int FW = DW + 2;
    localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;

    la_state_e state;
    la_state_e state_nxt;
    logic      trig_hit;
    logic      cap_en;

    logic [pSIG_WIDTH-1:0] sample;
    logic [pSIG_WIDTH-1:0] cur;
    logic [pCNT_WIDTH-1:0] cnt;
    logic                  run_vld;
    logic                  ovf_pend;
    logic                  first_pend;

    logic          emit;
    logic          pop;
    logic          can_push;
    logic          send_mark;
    logic          push_rec;
    logic          drop;
    logic          push;
    logic [1:0]    push_user;
    logic [FW-1:0] push_word;
    logic [FW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;

    assign trig_hit = ((la_data & trig_mask) == (trig_value & trig_mask));
    assign sample   = la_data & la_mask;

    // Capture state register.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: enable low always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (!la_enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = trig_mode ? ARMED : CAPTURE;
                ARMED:   if (trig_hit) state_nxt = CAPTURE;
                CAPTURE: state_nxt = CAPTURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sampling is live only while capturing and still enabled.
    always_comb begin
        cap_en = la_enable && (state == CAPTURE);
    end

    assign emit      = cap_en && run_vld
                     && ((sample != cur) || (cnt == CNT_MAX));
    assign pop       = m_tvalid && m_tready;
    assign can_push  = !fifo_full || pop;
    assign send_mark = cap_en && ovf_pend && can_push;
    assign push_rec  = emit && !ovf_pend && can_push;
    assign drop      = emit && !push_rec;
    assign push      = send_mark || push_rec;

    // Record word: the overflow marker replaces the run count with zero.
    always_comb begin
        push_user              = '0;
        push_user[TUSER_OVF]   = send_mark;
        push_user[TUSER_FIRST] = first_pend;
        push_word = {push_user,
                     send_mark ? pCNT_WIDTH'(MARKER_CNT) : cnt,
                     cur};
    end

    // Run tracking, overflow bookkeeping and drain-request hysteresis.
    always_ff @(posedge axis_clk) begin
        if (axis_rst || !la_enable) begin
            cur         <= '0;
            cnt         <= '0;
            run_vld     <= 1'b0;
            ovf_pend    <= 1'b0;
            first_pend  <= 1'b0;
            drop_cnt    <= '0;
            la_hpri_req <= 1'b0;
        end else begin
            if (cap_en && !run_vld) begin
                cur        <= sample;
                cnt        <= pCNT_WIDTH'(1);
                run_vld    <= 1'b1;
                first_pend <= 1'b1;
            end else if (emit) begin
                cur <= sample;
                cnt <= pCNT_WIDTH'(1);
            end else if (cap_en) begin
                cnt <= cnt + pCNT_WIDTH'(1);
            end
            if (push) first_pend <= 1'b0;
            if (send_mark)  ovf_pend <= 1'b0;
            else if (drop)  ovf_pend <= 1'b1;
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            if (fifo_level >= hi_thresh)      la_hpri_req <= 1'b1;
            else if (fifo_level <= lo_thresh) la_hpri_req <= 1'b0;
        end
    end

    la_sync_fifo #(
        .pWIDTH (FW),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .clr      (!la_enable),
        .push     (push),
        .wr_data  (push_word),
        .pop      (pop),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? head[DW-1:0] : '0;
    assign m_tuser  = m_tvalid ? head[FW-1:DW] : 2'b00;
    assign m_tlast  = (fifo_level == LW'(1));
    assign m_tstrb  = '1;
    assign m_tkeep  = '1;

endmodule
